// File: rtl/mmda_pkg.sv
// -----------------------------------------------------------------------------
// mmda_pkg
// Shared constants and the operand loader state type for the mmda blocks.
//   DATA_W        : width of one operand element (bits)
//   NUM_MAT       : matrix elements a..j (3x3)
//   NUM_VEC       : vector elements c0..c2
//   NUM_OPERANDS  : total bytes in one operand set
//   IDX_W         : width of the stream index
//   CNT_W         : width of the compute wait counter
// -----------------------------------------------------------------------------
package mmda_pkg;

  localparam int DATA_W       = 8;
  localparam int NUM_MAT      = 9;
  localparam int NUM_VEC      = 3;
  localparam int NUM_OPERANDS = 12;
  localparam int IDX_W        = 4;
  localparam int CNT_W        = 8;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } loader_state_t;

endpackage : mmda_pkg

// File: rtl/mmda_wait_counter.sv
// -----------------------------------------------------------------------------
// mmda_wait_counter
// Counts cycles while the mmda core is computing and flags the last one.
// Ports:
//   clk      : rising-edge clock
//   reset    : asynchronous active-high reset (count -> 0)
//   i_clear  : synchronous clear (priority over enable)
//   i_enable : advance the count by one
//   o_tc     : count equals TERMINAL
// The counter is CNT_W (8) bits; with TERMINAL <= 254 it reaches at most 255.
// -----------------------------------------------------------------------------
module mmda_wait_counter
  import mmda_pkg::*;
#(
  parameter int unsigned TERMINAL = 7
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_tc
);

  localparam logic [CNT_W-1:0] L_TC = CNT_W'(TERMINAL);

  logic [CNT_W-1:0] r_count;

  // Cycle counter: clear dominates, otherwise count up when enabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= {CNT_W{1'b0}};
    end else if (i_clear) begin
      r_count <= {CNT_W{1'b0}};
    end else if (i_enable) begin
      r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_count <= r_count;
    end
  end

  assign o_tc = (r_count == L_TC);

endmodule : mmda_wait_counter

// File: rtl/mmda_operand_loader.sv
// -----------------------------------------------------------------------------
// mmda_operand_loader
// Collects a 12-byte operand stream (a,b,c,d,e,f,g,h,j,c0,c1,c2) into frozen
// matrix/vector registers, pulses start_o for the mmda core, then holds the
// operands for COMPUTE_CYCLES cycles and pulses res_valid_o when the core
// result is valid.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   s_data       : operand byte
//   s_valid      : s_data is valid
//   s_ready      : byte accepted this cycle (high only in LOAD)
//   abort        : (MMDA_LOADER_ABORT_EN only) restart the set from index 0
//   mat_o        : byte k = matrix element k (a..j)
//   vec_o        : byte k = vector element ck
//   start_o      : one-cycle pulse, operand set complete
//   busy_o       : core computing, operands frozen
//   res_valid_o  : one-cycle pulse, core outputs valid
// Build option: define MMDA_LOADER_ABORT_EN to add the abort input.
// -----------------------------------------------------------------------------
module mmda_operand_loader
  import mmda_pkg::*;
#(
  parameter int unsigned COMPUTE_CYCLES = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [DATA_W-1:0]           s_data,
  input  logic                        s_valid,
  output logic                        s_ready,
`ifdef MMDA_LOADER_ABORT_EN
  input  logic                        abort,
`endif
  output logic [NUM_MAT*DATA_W-1:0]   mat_o,
  output logic [NUM_VEC*DATA_W-1:0]   vec_o,
  output logic                        start_o,
  output logic                        busy_o,
  output logic                        res_valid_o
);

  localparam logic [IDX_W-1:0] L_LAST_IDX = IDX_W'(NUM_OPERANDS - 1);

  loader_state_t             r_state;
  loader_state_t             w_state_next;
  logic [IDX_W-1:0]          r_idx;
  logic [NUM_MAT*DATA_W-1:0] r_mat;
  logic [NUM_VEC*DATA_W-1:0] r_vec;
  logic                      w_in_load;
  logic                      w_abort;
  logic                      w_accept;
  logic                      w_last;
  logic                      w_cnt_clear;
  logic                      w_cnt_en;
  logic                      w_tc;

  assign w_in_load = (r_state == LOAD);

`ifdef MMDA_LOADER_ABORT_EN
  // Abort only matters while loading; START/WAIT ignore it.
  assign w_abort = abort & w_in_load;
`else
  assign w_abort = 1'b0;
`endif

  // An aborted cycle discards the presented byte.
  assign w_accept = s_valid & w_in_load & ~w_abort;
  assign w_last   = (r_idx == L_LAST_IDX);

  // The terminal compare fires on the last WAIT cycle: the counter is cleared
  // entering WAIT, so after COMPUTE_CYCLES-1 increments we are at S+COMPUTE_CYCLES.
  mmda_wait_counter #(
    .TERMINAL (COMPUTE_CYCLES - 1)
  ) u_wait_counter (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (w_cnt_clear),
    .i_enable (w_cnt_en),
    .o_tc     (w_tc)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= LOAD;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state, counter control and state-decoded outputs.
  always_comb begin
    w_state_next = r_state;
    w_cnt_clear  = 1'b0;
    w_cnt_en     = 1'b0;
    s_ready      = 1'b0;
    start_o      = 1'b0;
    busy_o       = 1'b0;
    res_valid_o  = 1'b0;
    case (r_state)
      LOAD: begin
        s_ready = 1'b1;
        if (w_accept && w_last) begin
          w_state_next = START;
        end else begin
          w_state_next = LOAD;
        end
      end
      START: begin
        start_o      = 1'b1;
        busy_o       = 1'b1;
        w_cnt_clear  = 1'b1;
        w_state_next = WAIT;
      end
      WAIT: begin
        busy_o   = 1'b1;
        w_cnt_en = 1'b1;
        if (w_tc) begin
          res_valid_o  = 1'b1;
          w_state_next = LOAD;
        end else begin
          w_state_next = WAIT;
        end
      end
      default: begin
        w_state_next = LOAD;
      end
    endcase
  end

  // Stream index: restarts on abort or after the last byte of a set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx <= {IDX_W{1'b0}};
    end else if (w_abort) begin
      r_idx <= {IDX_W{1'b0}};
    end else if (w_accept) begin
      if (w_last) begin
        r_idx <= {IDX_W{1'b0}};
      end else begin
        r_idx <= r_idx + {{(IDX_W-1){1'b0}}, 1'b1};
      end
    end else begin
      r_idx <= r_idx;
    end
  end

  // Operand slots: an accepted byte lands in the slot selected by the index.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mat <= {(NUM_MAT*DATA_W){1'b0}};
      r_vec <= {(NUM_VEC*DATA_W){1'b0}};
    end else begin
      for (int k = 0; k < NUM_MAT; k++) begin
        if (w_accept && (r_idx == IDX_W'(k))) begin
          r_mat[k*DATA_W +: DATA_W] <= s_data;
        end
      end
      for (int k = 0; k < NUM_VEC; k++) begin
        if (w_accept && (r_idx == IDX_W'(NUM_MAT + k))) begin
          r_vec[k*DATA_W +: DATA_W] <= s_data;
        end
      end
    end
  end

  assign mat_o = r_mat;
  assign vec_o = r_vec;

endmodule : mmda_operand_loader

// File: tb/tb_mmda_operand_loader.sv
// -----------------------------------------------------------------------------
// tb_mmda_operand_loader
// Directed bench for mmda_operand_loader (COMPUTE_CYCLES = 8). Inputs are
// driven around the falling edge / just after the rising edge; outputs are
// sampled on the falling edge. Define MMDA_LOADER_ABORT_EN to include the
// abort scenarios.
// -----------------------------------------------------------------------------
module tb_mmda_operand_loader;

  localparam int C = 8;

  logic        clk;
  logic        reset;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic        abort;
  logic [71:0] mat_o;
  logic [23:0] vec_o;
  logic        start_o;
  logic        busy_o;
  logic        res_valid_o;

  int checks;
  int failures;

  mmda_operand_loader #(
    .COMPUTE_CYCLES (C)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
`ifdef MMDA_LOADER_ABORT_EN
    .abort       (abort),
`endif
    .mat_o       (mat_o),
    .vec_o       (vec_o),
    .start_o     (start_o),
    .busy_o      (busy_o),
    .res_valid_o (res_valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference mmda core: y_r = sum_j M[r][j] * c_j.
  function automatic int core_y(input logic [71:0] m, input logic [23:0] v, input int r);
    int s;
    s = 0;
    for (int j = 0; j < 3; j++) begin
      s += int'(m[(3*r+j)*8 +: 8]) * int'(v[j*8 +: 8]);
    end
    return s;
  endfunction

  // Present one byte and wait (bounded) until it is accepted.
  task automatic send_byte(input logic [7:0] b);
    bit done;
    done = 1'b0;
    for (int t = 0; t < 40 && !done; t++) begin
      @(negedge clk);
      if (s_ready) begin
        s_valid = 1'b1;
        s_data  = b;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        done    = 1'b1;
      end
    end
    if (!done) check("send_ready_timeout", {71'd0, s_ready}, 72'd1);
  endtask

  task automatic send_set(input logic [71:0] m, input logic [23:0] v, input bit gaps);
    logic [7:0] b;
    for (int i = 0; i < 12; i++) begin
      if (i < 9) b = m[i*8 +: 8];
      else       b = v[(i-9)*8 +: 8];
      if (gaps && (i % 3 == 1)) begin
        s_data = 8'hEE;
        repeat (2) @(negedge clk);
      end
      send_byte(b);
    end
  endtask

  // Called right after the 12th accepting edge (inside cycle S).
  task automatic run_compute(input logic [71:0] em, input logic [23:0] ev, input bit hold);
    @(negedge clk);
    if (hold) begin
      s_valid = 1'b1;
      s_data  = 8'hFF;
    end
    check("S_start", {71'd0, start_o}, 72'd1);
    check("S_busy", {71'd0, busy_o}, 72'd1);
    check("S_ready", {71'd0, s_ready}, 72'd0);
    check("S_mat", mat_o, em);
    check("S_vec", {48'd0, vec_o}, {48'd0, ev});
    for (int k = 1; k <= C; k++) begin
      @(negedge clk);
      check("W_start", {71'd0, start_o}, 72'd0);
      check("W_busy", {71'd0, busy_o}, 72'd1);
      check("W_ready", {71'd0, s_ready}, 72'd0);
      check("W_res_valid", {71'd0, res_valid_o}, (k == C) ? 72'd1 : 72'd0);
      if (hold || k == C) begin
        check("W_mat", mat_o, em);
        check("W_vec", {48'd0, vec_o}, {48'd0, ev});
      end
      if (k == C) begin
        for (int r = 0; r < 3; r++)
          check("W_core_y", 72'(core_y(mat_o, vec_o, r)), 72'(core_y(em, ev, r)));
      end
    end
    @(negedge clk);
    s_valid = 1'b0;
    abort   = 1'b0;
    check("L_ready", {71'd0, s_ready}, 72'd1);
    check("L_busy", {71'd0, busy_o}, 72'd0);
    check("L_res_valid", {71'd0, res_valid_o}, 72'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mat"}, mat_o, 72'd0);
    check({tag, "_vec"}, {48'd0, vec_o}, 72'd0);
    check({tag, "_start"}, {71'd0, start_o}, 72'd0);
    check({tag, "_busy"}, {71'd0, busy_o}, 72'd0);
    check({tag, "_res_valid"}, {71'd0, res_valid_o}, 72'd0);
    check({tag, "_ready"}, {71'd0, s_ready}, 72'd1);
  endtask

  // Watch a window for stray pulses after an abandoned set.
  task automatic expect_quiet(input string tag, input int cycles);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      seen = seen | start_o | res_valid_o | busy_o;
    end
    check(tag, {71'd0, seen}, 72'd0);
  endtask

  localparam logic [71:0] M1 = 72'h090807060504030201;
  localparam logic [23:0] V1 = 24'h030201;
  localparam logic [71:0] M2 = 72'h181716151413121110;
  localparam logic [23:0] V2 = 24'h222120;
  localparam logic [71:0] M3 = 72'h484746454443424140;
  localparam logic [23:0] V3 = 24'h4B4A49;

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    s_valid  = 1'b0;
    s_data   = 8'h00;
    abort    = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("post_rst");

    // Basic set, s_valid continuous, then check core results.
    send_set(M1, V1, 1'b0);
    run_compute(M1, V1, 1'b0);
    check("y0", 72'(core_y(mat_o, vec_o, 0)), 72'd14);
    check("y1", 72'(core_y(mat_o, vec_o, 1)), 72'd32);
    check("y2", 72'(core_y(mat_o, vec_o, 2)), 72'd50);

    // Clear slots, then same set with s_valid gaps and s_valid held in WAIT.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    send_set(M1, V1, 1'b1);
    run_compute(M1, V1, 1'b1);

    // Reset after 5 accepted bytes abandons the partial set.
    for (int i = 0; i < 5; i++) send_byte(8'hA0 + 8'(i));
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("midload_rst");
    reset = 1'b0;
    expect_quiet("midload_quiet", 4);
    send_set(M2, V2, 1'b0);
    run_compute(M2, V2, 1'b0);

    // Reset in the middle of WAIT: no res_valid_o afterwards.
    send_set(M1, V1, 1'b0);
    repeat (3) @(negedge clk);
    check("midwait_busy", {71'd0, busy_o}, 72'd1);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("midwait_rst");
    reset = 1'b0;
    expect_quiet("midwait_quiet", C + 3);

`ifdef MMDA_LOADER_ABORT_EN
    // Abort after 7 bytes coincident with a valid byte, then a full set;
    // abort held through START/WAIT has no effect.
    for (int i = 0; i < 7; i++) send_byte(8'h30 + 8'(i));
    @(negedge clk);
    abort   = 1'b1;
    s_valid = 1'b1;
    s_data  = 8'h77;
    @(posedge clk);
    #1;
    abort   = 1'b0;
    s_valid = 1'b0;
    @(negedge clk);
    check("abort_ready", {71'd0, s_ready}, 72'd1);
    check("abort_start", {71'd0, start_o}, 72'd0);
    check("abort_slot6_kept", {64'd0, mat_o[55:48]}, 72'h36);
    send_set(M3, V3, 1'b0);
    abort = 1'b1;
    run_compute(M3, V3, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_mmda_operand_loader

// File: doc/mmda_operand_loader.md
MMDA_OPERAND_LOADER -- requirements
Module: mmda_operand_loader

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, named clk and reset as in the rest of the mmda blocks.
REQ-002 Parameter COMPUTE_CYCLES, default 8: number of cycles the mmda core needs per matrix-vector product (legal range 1..255).
REQ-003 Port clk, input, 1 bit: rising-edge clock.
REQ-004 Port reset, input, 1 bit: asynchronous active-high reset.
REQ-005 Port s_data, input, 8 bits: operand byte stream.
REQ-006 Port s_valid, input, 1 bit: s_data is valid.
REQ-007 Port s_ready, output, 1 bit: the loader accepts a byte this cycle.
REQ-008 Port mat_o, output, 72 bits: matrix elements; byte k (bits 8k+7:8k) is element k in order a,b,c,d,e,f,g,h,j.
REQ-009 Port vec_o, output, 24 bits: vector elements; byte 0 is c0, byte 1 is c1, byte 2 is c2.
REQ-010 Port start_o, output, 1 bit: one-cycle pulse, operand set complete.
REQ-011 Port busy_o, output, 1 bit: core computing; operands are frozen.
REQ-012 Port res_valid_o, output, 1 bit: one-cycle pulse, core outputs y0..y2 are valid.

Function
REQ-013 A byte SHALL be accepted on a rising edge where s_valid and s_ready are both 1.
REQ-014 Stream order SHALL be a,b,c,d,e,f,g,h,j,c0,c1,c2 (index 0..11); each accepted byte SHALL be written into its slot at the accepting edge.
REQ-015 The FSM SHALL have states LOAD, START and WAIT; s_ready SHALL be 1 only in LOAD (decoded from state only).
REQ-016 LOAD: accepting index 11 SHALL move to START and clear the index; any other accept SHALL increment the index.
REQ-017 START (cycle S): start_o=1 and busy_o=1; the next state SHALL be WAIT with the wait counter cleared.
REQ-018 WAIT: busy_o=1; the counter SHALL increment each cycle, and res_valid_o=1 in cycle S+COMPUTE_CYCLES, after which the next state SHALL be LOAD.
REQ-019 s_ready SHALL return to 1 in cycle S+COMPUTE_CYCLES+1; back-to-back sets SHALL add no extra idle cycles.
REQ-020 mat_o and vec_o SHALL NOT change from cycle S through S+COMPUTE_CYCLES.
REQ-021 A gap in s_valid during LOAD SHALL hold the index; bytes presented while s_ready=0 SHALL be ignored, with no state change.
REQ-022 The wait counter SHALL be 8 bits wide and SHALL never wrap within the legal COMPUTE_CYCLES range.

Reset
REQ-023 Reset SHALL force: state LOAD, index 0, counter 0, mat_o=0, vec_o=0, start_o=0, busy_o=0 and res_valid_o=0. Because s_ready is decoded from state, it is 1 while reset is held and remains 1 after release.
REQ-024 Reset asserted mid-load or mid-WAIT SHALL abandon the set; no start_o or res_valid_o pulse SHALL follow it.

Configuration
REQ-025 Macro MMDA_LOADER_ABORT_EN, when defined, SHALL add a 1-bit input abort. In LOAD, abort=1 SHALL clear the index to 0 and discard any simultaneously presented byte; slot contents SHALL be kept. In START and WAIT, abort SHALL be ignored.
REQ-026 When MMDA_LOADER_ABORT_EN is undefined, the abort port and its logic SHALL be absent.

Structure
REQ-027 Package mmda_pkg SHALL hold DATA_W=8, NUM_MAT=9, NUM_VEC=3, NUM_OPERANDS=12 and the loader state enum.
REQ-028 A single sub-module, mmda_wait_counter (clear, enable, terminal-count compare), SHALL implement REQ-018; everything else SHALL be in the top module.

Verification
REQ-029 Reset, then stream bytes 1..9 and 1,2,3 with s_valid held high -> start_o in the cycle after the 12th accept; mat_o byte k = k+1; vec_o=24'h030201.
REQ-030 Same set with COMPUTE_CYCLES=8 -> busy_o high for 9 cycles, res_valid_o in cycle S+8, s_ready=1 in cycle S+9; a core connected to the outputs yields y0=14, y1=32, y2=50.
REQ-031 Random s_valid gaps in LOAD, plus s_valid held high during WAIT -> same mat_o/vec_o values as REQ-029, no extra accepts, operands stable through WAIT.
REQ-032 Reset pulse after 5 accepted bytes, then a full new set -> all outputs 0 during reset, no start_o from the partial set, new set loaded from index 0.
REQ-033 With MMDA_LOADER_ABORT_EN: abort after 7 bytes, coincident with a valid byte -> that byte is discarded and the next 12 bytes form a complete set; abort during WAIT -> no effect.
